// File: rtl/free_list_alloc_if.sv
// free_list_alloc_if: allocation offer/grant and free-return bus of the free-list allocator
interface free_list_alloc_if #(parameter int WIDTH = 64, parameter int FREE_PORTS = 2);
  localparam int IW = $clog2(WIDTH);
  logic [1:0] alloc_req;
  logic [1:0] alloc_avail;
  logic [IW-1:0] alloc_idx_0;
  logic [IW-1:0] alloc_idx_1;
  logic [FREE_PORTS-1:0] free_en;
  logic [FREE_PORTS-1:0][IW-1:0] free_idx;
  logic [IW:0] free_count;
  logic double_free;
  modport master(output alloc_req, free_en, free_idx,
                 input alloc_avail, alloc_idx_0, alloc_idx_1, free_count, double_free);
  modport slave(input alloc_req, free_en, free_idx,
                output alloc_avail, alloc_idx_0, alloc_idx_1, free_count, double_free);
endinterface

// File: rtl/free_list_alloc.sv
// free_list_alloc: registered free bitmap offering lowest/highest free index with multi-port returns
module free_list_alloc #(
  parameter int WIDTH = 64,
  parameter int FREE_PORTS = 2,
  parameter int RESET_BUSY = 32
) (
  input logic clk,
  input logic rst_n,
  free_list_alloc_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] RST_MAP = {WIDTH{1'b1}} << RESET_BUSY;
  logic [WIDTH-1:0] map_q, map_d, grant_mask, free_mask;
  logic [IW-1:0] idx0_q, idx0_d, idx1_q, idx1_d;
  logic [1:0] avail_q, avail_d;
  logic [IW:0] count_q, count_d;
  logic dfree_q, dfree_d, g0, g1;
  always_comb begin
    g0 = bus.alloc_req[0] & avail_q[0];
    g1 = bus.alloc_req[1] & avail_q[1];
    grant_mask = '0;
    if (g0) grant_mask[idx0_q] = 1'b1;
    if (g1) grant_mask[idx1_q] = 1'b1;
    free_mask = '0;
    dfree_d = dfree_q;
    count_d = count_q - (IW+1)'(g0) - (IW+1)'(g1);
    for (int k = 0; k < FREE_PORTS; k++)
      if (bus.free_en[k]) begin
        if (map_q[bus.free_idx[k]] | free_mask[bus.free_idx[k]]) dfree_d = 1'b1;
        else begin
          free_mask[bus.free_idx[k]] = 1'b1;
          count_d = count_d + (IW+1)'(1);
        end
      end
    map_d = (map_q & ~grant_mask) | free_mask;
    idx0_d = '0;
    idx1_d = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (map_d[i]) idx0_d = IW'(i);
    for (int i = 0; i < WIDTH; i++) if (map_d[i]) idx1_d = IW'(i);
    avail_d = {count_d > (IW+1)'(1), count_d != '0};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      map_q <= RST_MAP;
      idx0_q <= IW'(RESET_BUSY);
      idx1_q <= IW'(WIDTH - 1);
      avail_q <= 2'b11;
      count_q <= (IW+1)'(WIDTH - RESET_BUSY);
      dfree_q <= 1'b0;
    end else begin
      map_q <= map_d;
      idx0_q <= idx0_d;
      idx1_q <= idx1_d;
      avail_q <= avail_d;
      count_q <= count_d;
      dfree_q <= dfree_d;
    end
  end
  assign bus.alloc_avail = avail_q;
  assign bus.alloc_idx_0 = idx0_q;
  assign bus.alloc_idx_1 = idx1_q;
  assign bus.free_count = count_q;
  assign bus.double_free = dfree_q;
endmodule

// File: tb/tb_free_list_alloc.sv
// tb_free_list_alloc: directed spec scenarios plus randomized traffic against a bitmap reference model
module tb_free_list_alloc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [63:0] m;
  bit mdf;
  free_list_alloc_if #(.WIDTH(64), .FREE_PORTS(2)) bus();
  free_list_alloc #(.WIDTH(64), .FREE_PORTS(2), .RESET_BUSY(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic int lowest(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int highest(input logic [63:0] v);
    for (int i = 63; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m = {{32{1'b1}}, {32{1'b0}}};
    mdf = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] req, input logic [1:0] en, input logic [5:0] i0, input logic [5:0] i1);
    logic [63:0] nm;
    int c;
    c = $countones(m);
    nm = m;
    if (req[0] && c >= 1) nm[lowest(m)] = 1'b0;
    if (req[1] && c >= 2) nm[highest(m)] = 1'b0;
    if (en[0]) begin
      if (m[i0]) mdf = 1'b1;
      else nm[i0] = 1'b1;
    end
    if (en[1]) begin
      if (m[i1] || (en[0] && i0 == i1)) mdf = 1'b1;
      else nm[i1] = 1'b1;
    end
    m = nm;
  endtask

  task automatic cycle(input logic [1:0] req, input logic [1:0] en, input logic [5:0] i0, input logic [5:0] i1);
    bus.alloc_req = req;
    bus.free_en = en;
    bus.free_idx[0] = i0;
    bus.free_idx[1] = i1;
    model_step(req, en, i0, i1);
    @(posedge clk);
    #1;
    bus.alloc_req = 2'b00;
    bus.free_en = 2'b00;
  endtask

  task automatic test_reset();
    bus.alloc_req = 2'b00;
    bus.free_en = 2'b00;
    bus.free_idx = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    checks++; if (bus.alloc_idx_0 !== 6'd32) begin failures++; $display("FAIL reset_idx0 got=%0d exp=32", bus.alloc_idx_0); end
    checks++; if (bus.alloc_idx_1 !== 6'd63) begin failures++; $display("FAIL reset_idx1 got=%0d exp=63", bus.alloc_idx_1); end
    checks++; if (bus.alloc_avail !== 2'b11) begin failures++; $display("FAIL reset_avail got=%b exp=11", bus.alloc_avail); end
    checks++; if (bus.free_count !== 7'd32) begin failures++; $display("FAIL reset_count got=%0d exp=32", bus.free_count); end
    checks++; if (bus.double_free !== 1'b0) begin failures++; $display("FAIL reset_dfree got=%b exp=0", bus.double_free); end
  endtask

  task automatic test_dual_grant();
    cycle(2'b11, 2'b00, 6'd0, 6'd0);
    checks++; if (bus.alloc_idx_0 !== 6'd33) begin failures++; $display("FAIL grant_idx0 got=%0d exp=33", bus.alloc_idx_0); end
    checks++; if (bus.alloc_idx_1 !== 6'd62) begin failures++; $display("FAIL grant_idx1 got=%0d exp=62", bus.alloc_idx_1); end
    checks++; if (bus.free_count !== 7'd30) begin failures++; $display("FAIL grant_count got=%0d exp=30", bus.free_count); end
  endtask

  task automatic test_drain();
    repeat (16) cycle(2'b11, 2'b00, 6'd0, 6'd0);
    for (int r = 0; r < 3; r++) begin
      checks++; if (bus.free_count !== 7'd0) begin failures++; $display("FAIL drain_count r=%0d got=%0d exp=0", r, bus.free_count); end
      checks++; if (bus.alloc_avail !== 2'b00) begin failures++; $display("FAIL drain_avail r=%0d got=%b exp=00", r, bus.alloc_avail); end
      checks++; if (bus.alloc_idx_0 !== 6'd0 || bus.alloc_idx_1 !== 6'd0) begin failures++; $display("FAIL drain_idx r=%0d got=%0d/%0d exp=0/0", r, bus.alloc_idx_0, bus.alloc_idx_1); end
      cycle(2'b11, 2'b00, 6'd0, 6'd0);
    end
  endtask

  task automatic test_single_entry();
    cycle(2'b00, 2'b01, 6'd5, 6'd0);
    checks++; if (bus.alloc_avail !== 2'b01) begin failures++; $display("FAIL single_avail got=%b exp=01", bus.alloc_avail); end
    checks++; if (bus.alloc_idx_0 !== 6'd5 || bus.alloc_idx_1 !== 6'd5) begin failures++; $display("FAIL single_idx got=%0d/%0d exp=5/5", bus.alloc_idx_0, bus.alloc_idx_1); end
    checks++; if (bus.free_count !== 7'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.free_count); end
    cycle(2'b10, 2'b00, 6'd0, 6'd0);
    checks++; if (bus.free_count !== 7'd1 || bus.alloc_idx_0 !== 6'd5 || bus.double_free !== 1'b0) begin failures++; $display("FAIL single_ignore got=%0d/%0d/%b exp=1/5/0", bus.free_count, bus.alloc_idx_0, bus.double_free); end
    cycle(2'b01, 2'b00, 6'd0, 6'd0);
    checks++; if (bus.free_count !== 7'd0 || bus.alloc_avail !== 2'b00) begin failures++; $display("FAIL single_grant got=%0d/%b exp=0/00", bus.free_count, bus.alloc_avail); end
  endtask

  task automatic test_concurrent();
    cycle(2'b00, 2'b11, 6'd40, 6'd50);
    cycle(2'b00, 2'b01, 6'd45, 6'd0);
    checks++; if (bus.alloc_idx_0 !== 6'd40 || bus.alloc_idx_1 !== 6'd50) begin failures++; $display("FAIL conc_setup got=%0d/%0d exp=40/50", bus.alloc_idx_0, bus.alloc_idx_1); end
    cycle(2'b11, 2'b11, 6'd10, 6'd20);
    checks++; if (bus.free_count !== 7'd3) begin failures++; $display("FAIL conc_count got=%0d exp=3", bus.free_count); end
    checks++; if (bus.alloc_idx_0 !== 6'd10) begin failures++; $display("FAIL conc_idx0 got=%0d exp=10", bus.alloc_idx_0); end
    checks++; if (bus.alloc_idx_1 !== 6'd45) begin failures++; $display("FAIL conc_idx1 got=%0d exp=45", bus.alloc_idx_1); end
  endtask

  task automatic test_double_free();
    checks++; if (bus.double_free !== 1'b0) begin failures++; $display("FAIL df_pre got=%b exp=0", bus.double_free); end
    cycle(2'b00, 2'b01, 6'd45, 6'd0);
    checks++; if (bus.double_free !== 1'b1 || bus.free_count !== 7'd3) begin failures++; $display("FAIL df_already got=%b/%0d exp=1/3", bus.double_free, bus.free_count); end
    cycle(2'b00, 2'b11, 6'd7, 6'd7);
    checks++; if (bus.free_count !== 7'd4 || bus.alloc_idx_0 !== 6'd7) begin failures++; $display("FAIL df_dup got=%0d/%0d exp=4/7", bus.free_count, bus.alloc_idx_0); end
    repeat (3) cycle(2'b00, 2'b00, 6'd0, 6'd0);
    checks++; if (bus.double_free !== 1'b1) begin failures++; $display("FAIL df_sticky got=%b exp=1", bus.double_free); end
  endtask

  task automatic test_random();
    logic [1:0] req, en;
    logic [5:0] i0, i1;
    int c;
    for (int n = 0; n < 400; n++) begin
      req = 2'($urandom_range(0, 3));
      en = 2'($urandom_range(0, 3));
      i0 = 6'($urandom_range(0, 63));
      i1 = ($urandom_range(0, 7) == 0) ? i0 : 6'($urandom_range(0, 63));
      cycle(req, en, i0, i1);
      c = $countones(m);
      checks++; if (bus.free_count !== 7'(c)) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, bus.free_count, c); end
      checks++; if (bus.alloc_avail !== {c >= 2, c >= 1}) begin failures++; $display("FAIL rnd_avail n=%0d got=%b exp=%b", n, bus.alloc_avail, {c >= 2, c >= 1}); end
      checks++; if (bus.alloc_idx_0 !== 6'(lowest(m))) begin failures++; $display("FAIL rnd_idx0 n=%0d got=%0d exp=%0d", n, bus.alloc_idx_0, lowest(m)); end
      checks++; if (bus.alloc_idx_1 !== 6'(highest(m))) begin failures++; $display("FAIL rnd_idx1 n=%0d got=%0d exp=%0d", n, bus.alloc_idx_1, highest(m)); end
      checks++; if (bus.double_free !== mdf) begin failures++; $display("FAIL rnd_dfree n=%0d got=%b exp=%b", n, bus.double_free, mdf); end
    end
  endtask

  task automatic test_reset_priority();
    bus.alloc_req = 2'b11;
    bus.free_en = 2'b11;
    bus.free_idx[0] = 6'd3;
    bus.free_idx[1] = 6'd3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.alloc_req = 2'b00;
    bus.free_en = 2'b00;
    model_reset();
    checks++; if (bus.free_count !== 7'd32 || bus.alloc_avail !== 2'b11) begin failures++; $display("FAIL rstp_count got=%0d/%b exp=32/11", bus.free_count, bus.alloc_avail); end
    checks++; if (bus.alloc_idx_0 !== 6'd32 || bus.alloc_idx_1 !== 6'd63) begin failures++; $display("FAIL rstp_idx got=%0d/%0d exp=32/63", bus.alloc_idx_0, bus.alloc_idx_1); end
    checks++; if (bus.double_free !== 1'b0) begin failures++; $display("FAIL rstp_dfree got=%b exp=0", bus.double_free); end
  endtask

  initial begin
    test_reset();
    test_dual_grant();
    test_drain();
    test_single_entry();
    test_concurrent();
    test_double_free();
    test_random();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
